// File: rtl/sound_recorder_pkg.sv
// Shared definitions for the sound recorder capture path.
// FSM state encoding and datapath width defaults shared with the player datapath.
package sound_recorder_pkg;

    localparam int IN_W_DEF     = 32;
    localparam int SAMPLE_W_DEF = 10;
    localparam int ADDR_W_DEF   = 20;
    localparam int DECIM_DEF    = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } rec_state_e;

endpackage

// File: rtl/sound_recorder_rec_addr_counter.sv
// Sample RAM address counter for a recording take.
// Loads zero and latches the last address on clear; increments; flags terminal count.
module rec_addr_counter #(
    parameter int ADDR_W = 20
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] max_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] max_q, max_d;

    assign last_o = (addr_q == max_q);
    assign addr_o = addr_q;

    // Next address: zero on clear, +1 unless already at the latched max.
    always_comb begin
        addr_d = addr_q;
        max_d  = max_q;
        if (clear_i) begin
            addr_d = '0;
            max_d  = max_i;
        end else if (inc_i && !last_o) begin
            addr_d = addr_q + 1'b1;
        end
    end

    // Address and latched-max registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            max_q  <= '0;
        end else begin
            addr_q <= addr_d;
            max_q  <= max_d;
        end
    end

endmodule

// File: rtl/sound_recorder.sv
// Capture side of the audio path: codec input FIFO -> truncated samples -> sample RAM.
// Optional REC_DECIMATE_EN keeps one of every DECIM popped samples.
module sound_recorder
    import sound_recorder_pkg::*;
#(
    parameter int IN_W     = IN_W_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DECIM    = DECIM_DEF
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                record,
    input  logic [ADDR_W-1:0]   address_max,
    input  logic                audio_in_available,
    input  logic [IN_W-1:0]     audio_in,
    output logic                read_audio_in,
    output logic                clear_buffer,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [SAMPLE_W-1:0] ram_data,
    output logic                ram_wren,
    output logic                recording,
    output logic                done,
    output logic [ADDR_W:0]     rec_length
);

    if (DECIM < 2 || DECIM > 16) begin : g_decim_range
        $error("DECIM must be in 2..16");
    end

    rec_state_e          state_q, state_d;
    logic                record_q;
    logic                rise;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                cnt_last;
    logic [ADDR_W-1:0]   addr;
    logic                unused_lsbs;

    assign unused_lsbs = ^audio_in[IN_W-SAMPLE_W-1:0];
    assign rise        = record && !record_q;
    assign ram_address = addr;
    assign ram_data    = sample_q;
    assign rec_length  = len_q;

    rec_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk_i   (clock),
        .rst_ni  (resetn),
        .clear_i (cnt_clr),
        .inc_i   (cnt_inc),
        .max_i   (address_max),
        .addr_o  (addr),
        .last_o  (cnt_last)
    );

`ifdef REC_DECIMATE_EN
    logic [3:0] dec_q, dec_d;
    logic       keep;

    assign keep = (dec_q == 4'd0);

    // Mod-DECIM pop counter; only pops at count zero are written.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end
`else
    logic keep;

    assign keep = 1'b1;
`endif

    // State, record edge detector, sample and take-length registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            record_q <= 1'b0;
            sample_q <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            record_q <= record;
            sample_q <= sample_d;
            len_q    <= len_d;
        end
    end

    // Take sequencing: next state and one-cycle strobes.
    always_comb begin
        state_d       = state_q;
        sample_d      = sample_q;
        len_d         = len_q;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        read_audio_in = 1'b0;
        clear_buffer  = 1'b0;
        ram_wren      = 1'b0;
        recording     = 1'b0;
        done          = 1'b0;
`ifdef REC_DECIMATE_EN
        dec_d         = dec_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                clear_buffer = 1'b1;
                recording    = 1'b1;
                cnt_clr      = 1'b1;
                len_d        = '0;
`ifdef REC_DECIMATE_EN
                dec_d        = '0;
`endif
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                recording = 1'b1;
                if (!record) begin
                    state_d = S_DONE;
                end else if (audio_in_available) begin
                    read_audio_in = 1'b1;
                    sample_d      = audio_in[IN_W-1 -: SAMPLE_W];
`ifdef REC_DECIMATE_EN
                    dec_d = (dec_q == 4'(DECIM - 1)) ? 4'd0 : dec_q + 4'd1;
`endif
                    state_d = keep ? S_WRITE : S_WAIT;
                end
            end
            S_WRITE: begin
                recording = 1'b1;
                ram_wren  = 1'b1;
                len_d     = {1'b0, addr} + 1'b1;
                if (cnt_last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!record) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
